// File: rtl/uart_rx_decoder_pkg.sv
// Shared packet layout and protocol constants for the RX packet decoder.
package uart_rx_decoder_pkg;

  typedef enum logic [1:0] {
    PKT_UNUSED = 2'b00,
    PKT_DATA   = 2'b01,
    PKT_CFG_WR = 2'b10,
    PKT_CFG_RD = 2'b11
  } pkt_type_e;

  localparam int TYPE_LSB   = 0;
  localparam int TYPE_MSB   = 1;
  localparam int ID_LSB     = 2;
  localparam int ID_MSB     = 9;
  localparam int ADDR_LSB   = 10;
  localparam int ADDR_MSB   = 17;
  localparam int DATA_LSB   = 18;
  localparam int DATA_MSB   = 25;
  localparam int MAGIC_LSB  = 26;
  localparam int MAGIC_MSB  = 57;
  localparam int MARKER_BIT = 62;

  localparam logic [31:0] CFG_MAGIC = 32'h8950_4E47;
  localparam logic [7:0]  BCAST_ID  = 8'hFF;

endpackage

// File: rtl/uart_rx_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module uart_rx_decoder_sat_counter #(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_decoder.sv
// Unloads RX packets, executes config writes/reads locally and forwards data,
// foreign and broadcast packets plus read replies to the TX path.
module uart_rx_decoder
  import uart_rx_decoder_pkg::*;
#(
  parameter int          WIDTH        = 64,
  parameter int          FIFO_BITS    = 11,
  parameter logic [31:0] MAGIC        = CFG_MAGIC,
  parameter logic [7:0]  BROADCAST_ID = BCAST_ID
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           chip_id,
  input  logic [WIDTH-2:0]     rx_data,
  input  logic                 rx_empty,
  output logic                 uld_rx_data,
  output logic [7:0]           cfg_addr,
  output logic [7:0]           cfg_wdata,
  output logic                 cfg_we,
  input  logic [7:0]           cfg_rdata,
  output logic [WIDTH-2:0]     fwd_data,
  output logic                 fwd_valid,
  input  logic                 fwd_ready,
  input  logic                 clr_bad_packets,
  output logic [FIFO_BITS:0]   bad_packets,
  output logic                 busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_UNLOAD, ST_CAPTURE, ST_DECODE,
    ST_WRITE, ST_READ, ST_REPLY, ST_FWD
  } state_e;

  state_e           state_q;
  logic [WIDTH-2:0] pkt_q;
  logic             bcast_wr_q;
  logic             uld_q;
  logic             cfg_we_q;
  logic             fwd_valid_q;
  logic [7:0]       cfg_addr_q;
  logic [7:0]       cfg_wdata_q;

  pkt_type_e        pkt_type;
  logic             is_me, is_bcast, is_cfg, magic_ok, bad_pkt;

  always_comb begin
    pkt_type = pkt_type_e'(pkt_q[TYPE_MSB:TYPE_LSB]);
    is_me    = (pkt_q[ID_MSB:ID_LSB] == chip_id);
    is_bcast = (pkt_q[ID_MSB:ID_LSB] == BROADCAST_ID);
    is_cfg   = (pkt_type == PKT_CFG_WR) || (pkt_type == PKT_CFG_RD);
    magic_ok = (pkt_q[MAGIC_MSB:MAGIC_LSB] == MAGIC);
    bad_pkt  = 1'b0;
    if (state_q == ST_DECODE) begin
      bad_pkt = (pkt_type == PKT_UNUSED) || (is_cfg && (is_me || is_bcast) && !magic_ok);
    end
  end

  // Strobes default low every cycle so uld/we are single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pkt_q       <= '0;
      bcast_wr_q  <= 1'b0;
      uld_q       <= 1'b0;
      cfg_we_q    <= 1'b0;
      fwd_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
    end else begin
      uld_q    <= 1'b0;
      cfg_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rx_empty) begin
            uld_q   <= 1'b1;
            state_q <= ST_UNLOAD;
          end
        end
        ST_UNLOAD:  state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          pkt_q   <= rx_data;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          bcast_wr_q <= 1'b0;
          if (pkt_type == PKT_DATA || (is_cfg && !is_me && !is_bcast)) begin
            fwd_valid_q <= 1'b1;
            state_q     <= ST_FWD;
          end else if (bad_pkt) begin
            state_q <= ST_IDLE;
          end else if (pkt_type == PKT_CFG_WR) begin
            cfg_addr_q  <= pkt_q[ADDR_MSB:ADDR_LSB];
            cfg_wdata_q <= pkt_q[DATA_MSB:DATA_LSB];
            cfg_we_q    <= 1'b1;
            bcast_wr_q  <= is_bcast;
            state_q     <= ST_WRITE;
          end else if (is_bcast) begin
            // Broadcast reads have no single responder: pass along, no reply.
            fwd_valid_q <= 1'b1;
            state_q     <= ST_FWD;
          end else begin
            cfg_addr_q <= pkt_q[ADDR_MSB:ADDR_LSB];
            state_q    <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (bcast_wr_q) begin
            fwd_valid_q <= 1'b1;
            state_q     <= ST_FWD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ:  state_q <= ST_REPLY;
        ST_REPLY: begin
          pkt_q[DATA_MSB:DATA_LSB] <= cfg_rdata;
          pkt_q[MARKER_BIT]        <= 1'b1;
          fwd_valid_q              <= 1'b1;
          state_q                  <= ST_FWD;
        end
        ST_FWD: begin
          if (fwd_ready) begin
            fwd_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_rx_decoder_sat_counter #(
    .W(FIFO_BITS + 1)
  ) u_bad_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (bad_pkt),
    .clr_i   (clr_bad_packets),
    .count_o (bad_packets)
  );

  assign uld_rx_data = uld_q;
  assign cfg_addr    = cfg_addr_q;
  assign cfg_wdata   = cfg_wdata_q;
  assign cfg_we      = cfg_we_q;
  assign fwd_data    = pkt_q;
  assign fwd_valid   = fwd_valid_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Directed bench for uart_rx_decoder with an RX FIFO model and a register-file model.
module tb_uart_rx_decoder;

  localparam int          WIDTH     = 64;
  localparam int          FIFO_BITS = 11;
  localparam logic [31:0] GOOD      = 32'h8950_4E47;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        chip_id = 8'h10;
  logic [WIDTH-2:0]  rx_data = '0;
  logic              rx_empty = 1'b1;
  logic              uld_rx_data;
  logic [7:0]        cfg_addr, cfg_wdata;
  logic              cfg_we;
  logic [7:0]        cfg_rdata;
  logic [WIDTH-2:0]  fwd_data;
  logic              fwd_valid;
  logic              fwd_ready = 1'b1;
  logic              clr_bad_packets = 1'b0;
  logic [FIFO_BITS:0] bad_packets;
  logic              busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_rx_decoder #(
    .WIDTH(WIDTH), .FIFO_BITS(FIFO_BITS), .MAGIC(GOOD), .BROADCAST_ID(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .chip_id(chip_id), .rx_data(rx_data),
    .rx_empty(rx_empty), .uld_rx_data(uld_rx_data), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_we(cfg_we), .cfg_rdata(cfg_rdata),
    .fwd_data(fwd_data), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
    .clr_bad_packets(clr_bad_packets), .bad_packets(bad_packets), .busy(busy)
  );

  // RX UART model: unload presents the head packet on the following cycle.
  logic [WIDTH-2:0] rxq[$];
  always @(posedge clk) begin
    if (uld_rx_data && rxq.size() > 0) rx_data <= rxq.pop_front();
    rx_empty <= (rxq.size() == 0);
  end

  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (cfg_we) mem[cfg_addr] <= cfg_wdata;
    cfg_rdata <= mem[cfg_addr];
  end

  int cyc = 0, fwd_cnt = 0, we_cnt = 0, uld_cnt = 0;
  int last_fwd_cyc = 0, prev_fwd_cyc = 0, last_we_cyc = 0;
  logic [WIDTH-2:0] last_fwd = '0;
  logic [7:0] last_waddr = '0, last_wdata = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fwd_valid && fwd_ready) begin
      fwd_cnt <= fwd_cnt + 1; last_fwd <= fwd_data;
      prev_fwd_cyc <= last_fwd_cyc; last_fwd_cyc <= cyc;
    end
    if (cfg_we) begin
      we_cnt <= we_cnt + 1; last_waddr <= cfg_addr; last_wdata <= cfg_wdata; last_we_cyc <= cyc;
    end
    if (uld_rx_data) uld_cnt <= uld_cnt + 1;
  end

  function automatic logic [WIDTH-2:0] mk(input logic [1:0] t, input logic [7:0] id,
                                          input logic [7:0] addr, input logic [7:0] data,
                                          input logic [31:0] mg, input logic [4:0] hi);
    logic [WIDTH-2:0] p;
    p = '0;
    p[1:0] = t; p[9:2] = id; p[17:10] = addr; p[25:18] = data; p[57:26] = mg; p[62:58] = hi;
    return p;
  endfunction

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < budget; i++) begin
      if (!busy && rx_empty) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic measure_latency(output int lat);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rx_empty) begin seen = 1'b1; break; end
    end
    lat = 99;
    if (seen) begin
      lat = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); lat++;
        if (fwd_valid) break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (uld_rx_data !== 1'b0) begin tests_failed++; $display("FAIL reset_uld: got %0b want 0", uld_rx_data); end
    tests_run++; if (cfg_we !== 1'b0) begin tests_failed++; $display("FAIL reset_cfg_we: got %0b want 0", cfg_we); end
    tests_run++; if (fwd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_fwd_valid: got %0b want 0", fwd_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests_run++; if (bad_packets !== '0) begin tests_failed++; $display("FAIL reset_bad: got %0h want 0", bad_packets); end
    tests_run++; if (fwd_data !== '0) begin tests_failed++; $display("FAIL reset_fwd_data: got %0h want 0", fwd_data); end
    tests_run++; if ({cfg_addr, cfg_wdata} !== 16'h0) begin tests_failed++; $display("FAIL reset_cfg_bus: got %0h want 0", {cfg_addr, cfg_wdata}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_data_fwd();
    logic [WIDTH-2:0] p;
    int lat, f0; bit ok;
    p = mk(2'b01, 8'h05, 8'h11, 8'h22, 32'hDEAD_BEEF, 5'h0A);
    f0 = fwd_cnt;
    rxq.push_back(p);
    measure_latency(lat);
    tests_run++; if (lat != 4) begin tests_failed++; $display("FAIL data_latency: got %0d want 4", lat); end
    tests_run++; if (fwd_data !== p) begin tests_failed++; $display("FAIL data_payload: got %0h want %0h", fwd_data, p); end
    wait_done(50, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL data_timeout: got busy=%0b want idle", busy); end
    tests_run++; if (fwd_cnt - f0 != 1) begin tests_failed++; $display("FAIL data_fwd_count: got %0d want 1", fwd_cnt - f0); end
  endtask

  task automatic test_cfg_write();
    int f0, w0; bit ok;
    f0 = fwd_cnt; w0 = we_cnt;
    rxq.push_back(mk(2'b10, 8'h10, 8'h22, 8'hA5, GOOD, 5'h03));
    wait_done(50, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL wr_timeout: got busy=%0b want idle", busy); end
    tests_run++; if (we_cnt - w0 != 1) begin tests_failed++; $display("FAIL wr_we_pulses: got %0d want 1", we_cnt - w0); end
    tests_run++; if (fwd_cnt - f0 != 0) begin tests_failed++; $display("FAIL wr_no_fwd: got %0d want 0", fwd_cnt - f0); end
    tests_run++; if ({last_waddr, last_wdata} !== 16'h22A5) begin tests_failed++; $display("FAIL wr_addr_data: got %0h want 22a5", {last_waddr, last_wdata}); end
    tests_run++; if (cfg_addr !== 8'h22 || cfg_we !== 1'b0) begin tests_failed++; $display("FAIL wr_hold: got addr=%0h we=%0b want 22/0", cfg_addr, cfg_we); end
  endtask

  task automatic test_bcast_write();
    logic [WIDTH-2:0] p;
    int f0, w0; bit ok;
    p = mk(2'b10, 8'hFF, 8'h22, 8'h3C, GOOD, 5'h11);
    f0 = fwd_cnt; w0 = we_cnt;
    rxq.push_back(p);
    wait_done(50, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL bwr_timeout: got busy=%0b want idle", busy); end
    tests_run++; if (we_cnt - w0 != 1 || last_wdata !== 8'h3C) begin tests_failed++; $display("FAIL bwr_write: got %0d pulses data %0h want 1/3c", we_cnt - w0, last_wdata); end
    tests_run++; if (fwd_cnt - f0 != 1 || last_fwd !== p) begin tests_failed++; $display("FAIL bwr_fwd: got %0d pkts %0h want 1/%0h", fwd_cnt - f0, last_fwd, p); end
    tests_run++; if (last_fwd_cyc - last_we_cyc != 1) begin tests_failed++; $display("FAIL bwr_order: got %0d want 1", last_fwd_cyc - last_we_cyc); end
  endtask

  task automatic test_cfg_read();
    logic [WIDTH-2:0] exp;
    int lat, f0, w0; bit ok;
    exp = mk(2'b11, 8'h10, 8'h22, 8'h3C, GOOD, 5'h15);
    f0 = fwd_cnt; w0 = we_cnt;
    rxq.push_back(mk(2'b11, 8'h10, 8'h22, 8'h00, GOOD, 5'h05));
    measure_latency(lat);
    tests_run++; if (lat != 6) begin tests_failed++; $display("FAIL rd_latency: got %0d want 6", lat); end
    tests_run++; if (fwd_data !== exp) begin tests_failed++; $display("FAIL rd_reply: got %0h want %0h", fwd_data, exp); end
    wait_done(50, ok);
    tests_run++; if (!ok || fwd_cnt - f0 != 1 || we_cnt - w0 != 0) begin tests_failed++; $display("FAIL rd_counts: got fwd=%0d we=%0d want 1/0", fwd_cnt - f0, we_cnt - w0); end
  endtask

  task automatic test_foreign();
    logic [WIDTH-2:0] p;
    int f0, w0; bit ok;
    p = mk(2'b10, 8'h33, 8'h44, 8'h55, 32'h1234_5678, 5'h02);
    f0 = fwd_cnt; w0 = we_cnt;
    rxq.push_back(p);
    wait_done(50, ok);
    tests_run++; if (!ok || fwd_cnt - f0 != 1 || last_fwd !== p) begin tests_failed++; $display("FAIL foreign_fwd: got %0d pkts %0h want 1/%0h", fwd_cnt - f0, last_fwd, p); end
    tests_run++; if (we_cnt - w0 != 0 || bad_packets !== '0) begin tests_failed++; $display("FAIL foreign_side: got we=%0d bad=%0d want 0/0", we_cnt - w0, bad_packets); end
  endtask

  task automatic test_bad_packets();
    int f0, w0; bit ok;
    f0 = fwd_cnt; w0 = we_cnt;
    rxq.push_back(mk(2'b10, 8'h10, 8'h22, 8'h77, 32'h1234_5678, 5'h00));
    wait_done(50, ok);
    tests_run++; if (!ok || we_cnt - w0 != 0 || fwd_cnt - f0 != 0) begin tests_failed++; $display("FAIL badmagic_drop: got we=%0d fwd=%0d want 0/0", we_cnt - w0, fwd_cnt - f0); end
    tests_run++; if (bad_packets !== 12'd1) begin tests_failed++; $display("FAIL badmagic_count: got %0d want 1", bad_packets); end
    rxq.push_back(mk(2'b00, 8'h10, 8'h00, 8'h00, GOOD, 5'h00));
    wait_done(50, ok);
    tests_run++; if (!ok || bad_packets !== 12'd2 || fwd_cnt - f0 != 0) begin tests_failed++; $display("FAIL type0_count: got %0d want 2", bad_packets); end
  endtask

  task automatic test_saturation();
    bit ok;
    for (int i = 0; i < 4093; i++) rxq.push_back(mk(2'b00, 8'h00, 8'h00, 8'h00, 32'h0, 5'h00));
    wait_done(30000, ok);
    tests_run++; if (!ok || bad_packets !== 12'hFFF) begin tests_failed++; $display("FAIL sat_reach: got %0h want fff", bad_packets); end
    for (int i = 0; i < 2; i++) rxq.push_back(mk(2'b00, 8'h00, 8'h00, 8'h00, 32'h0, 5'h00));
    wait_done(100, ok);
    tests_run++; if (!ok || bad_packets !== 12'hFFF) begin tests_failed++; $display("FAIL sat_hold: got %0h want fff", bad_packets); end
    clr_bad_packets = 1'b1;
    rxq.push_back(mk(2'b00, 8'h00, 8'h00, 8'h00, 32'h0, 5'h00));
    wait_done(100, ok);
    clr_bad_packets = 1'b0;
    tests_run++; if (!ok || bad_packets !== 12'h000) begin tests_failed++; $display("FAIL clr_wins: got %0h want 0", bad_packets); end
    rxq.push_back(mk(2'b00, 8'h00, 8'h00, 8'h00, 32'h0, 5'h00));
    wait_done(100, ok);
    tests_run++; if (!ok || bad_packets !== 12'h001) begin tests_failed++; $display("FAIL count_after_clr: got %0h want 1", bad_packets); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-2:0] p1, p2;
    int f0, u0; bit ok;
    p1 = mk(2'b01, 8'h01, 8'h02, 8'h03, 32'hCAFE_F00D, 5'h1F);
    p2 = mk(2'b01, 8'h09, 8'h08, 8'h07, 32'h0BAD_BEEF, 5'h01);
    f0 = fwd_cnt; u0 = uld_cnt;
    rxq.push_back(p1); rxq.push_back(p2);
    wait_done(100, ok);
    tests_run++; if (!ok || fwd_cnt - f0 != 2 || uld_cnt - u0 != 2) begin tests_failed++; $display("FAIL b2b_counts: got fwd=%0d uld=%0d want 2/2", fwd_cnt - f0, uld_cnt - u0); end
    tests_run++; if (last_fwd !== p2) begin tests_failed++; $display("FAIL b2b_second: got %0h want %0h", last_fwd, p2); end
    tests_run++; if (last_fwd_cyc - prev_fwd_cyc != 5) begin tests_failed++; $display("FAIL b2b_gap: got %0d want 5", last_fwd_cyc - prev_fwd_cyc); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-2:0] pa, pb;
    int u0, errs; bit ok;
    pa = mk(2'b01, 8'h21, 8'h5A, 8'hC3, 32'h1111_2222, 5'h06);
    pb = mk(2'b01, 8'h42, 8'hA5, 8'h3C, 32'h3333_4444, 5'h19);
    fwd_ready = 1'b0;
    rxq.push_back(pa); rxq.push_back(pb);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fwd_valid) begin ok = 1'b1; break; end
    end
    tests_run++; if (!ok || fwd_data !== pa) begin tests_failed++; $display("FAIL bp_first: got %0h want %0h", fwd_data, pa); end
    u0 = uld_cnt; errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (fwd_data !== pa || fwd_valid !== 1'b1) errs++;
    end
    tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL bp_stable: got %0d bad cycles want 0", errs); end
    tests_run++; if (uld_cnt - u0 != 0 || rx_empty !== 1'b0) begin tests_failed++; $display("FAIL bp_no_unload: got %0d pulses empty=%0b want 0/0", uld_cnt - u0, rx_empty); end
    reset = 1'b1;
    #1;
    tests_run++; if (fwd_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midreset: got valid=%0b busy=%0b want 0/0", fwd_valid, busy); end
    tests_run++; if (bad_packets !== '0) begin tests_failed++; $display("FAIL midreset_bad: got %0h want 0", bad_packets); end
    @(negedge clk);
    reset = 1'b0;
    fwd_ready = 1'b1;
    wait_done(100, ok);
    tests_run++; if (!ok || last_fwd !== pb) begin tests_failed++; $display("FAIL after_reset_pkt: got %0h want %0h", last_fwd, pb); end
  endtask

  initial begin
    test_reset();
    test_data_fwd();
    test_cfg_write();
    test_bcast_write();
    test_cfg_read();
    test_foreign();
    test_bad_packets();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
